mem_port_arbiter: RTL and testbench

- Two-requester round-robin arbiter and burst sequencer for a single-port synchronous memory.
- The memory has an en/wr/addr interface with a 6-bit address.
- Serialises read or write bursts from two clients onto the shared en/wr/addr/wdata bus, with auto-incrementing addresses.
- Returns read data to the owning client with fixed latency; sits between client logic and the memory model.

---
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-client round-robin burst sequencer for a single-port memory
module mem_port_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              wr0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [LEN_W-1:0]  len0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [LEN_W-1:0]  len1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  logic [0:0]        state_q, state_d;
  logic              rr_last_q, rr_last_d;
  logic              owner_q, owner_d;
  logic              wr_q, wr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic              en_q, en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_owner_q, rd_owner_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              win;

  // On a tie the client that did not win last time goes next.
  assign win = (req0 & req1) ? ~rr_last_q : req1;

  always_comb begin
    state_d    = state_q;
    rr_last_d  = rr_last_q;
    owner_d    = owner_q;
    wr_d       = wr_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    gnt0_d     = gnt0_q;
    gnt1_d     = gnt1_q;
    en_d       = en_q;
    addr_d     = addr_q;
    case (state_q)
      S_IDLE: begin
        if (req0 | req1) begin
          state_d   = S_BURST;
          rr_last_d = win;
          owner_d   = win;
          wr_d      = win ? wr1 : wr0;
          len_d     = win ? len1 : len0;
          addr_d    = win ? addr1 : addr0;
          cnt_d     = '0;
          en_d      = 1'b1;
          gnt0_d    = ~win;
          gnt1_d    = win;
        end
      end
      S_BURST: begin
        if (cnt_q == len_q) begin
          state_d = S_IDLE;
          en_d    = 1'b0;
          gnt0_d  = 1'b0;
          gnt1_d  = 1'b0;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          addr_d = addr_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    rd_pend_d  = en_q & ~wr_q;
    rd_owner_d = owner_q;
    rdata_d    = rd_pend_q ? mem_rdata : rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rr_last_q  <= 1'b1;
      owner_q    <= 1'b0;
      wr_q       <= 1'b0;
      len_q      <= '0;
      cnt_q      <= '0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      en_q       <= 1'b0;
      addr_q     <= '0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_last_q  <= rr_last_d;
      owner_q    <= owner_d;
      wr_q       <= wr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      en_q       <= en_d;
      addr_q     <= addr_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
      rdata_q    <= rdata_d;
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign busy      = (state_q == S_BURST);
  assign mem_en    = en_q;
  // Bus is parked at zero between bursts so IDLE cycles are unambiguous.
  assign mem_wr    = en_q & wr_q;
  assign mem_addr  = en_q ? addr_q : '0;
  assign mem_wdata = (state_q == S_BURST) ? (owner_q ? wdata1 : wdata0) : '0;
  assign rvalid0   = rd_pend_q & ~rd_owner_q;
  assign rvalid1   = rd_pend_q & rd_owner_q;
  assign rdata     = rd_pend_q ? mem_rdata : rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - table-driven bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, wr0 = 1'b0, req1 = 1'b0, wr1 = 1'b0;
  logic [5:0] addr0 = '0, addr1 = '0;
  logic [1:0] len0 = '0, len1 = '0;
  logic [7:0] wdata0 = '0, wdata1 = '0;
  logic       gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_wr, busy;
  logic [7:0] rdata, mem_wdata;
  logic [5:0] mem_addr;
  logic [7:0] mem_rdata = 8'h00;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .wr0(wr0), .addr0(addr0), .len0(len0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0),
    .req1(req1), .wr1(wr1), .addr1(addr1), .len1(len1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1),
    .rdata(rdata), .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  // Memory returns address + 0x40 one cycle after a read beat.
  always @(posedge clk) begin
    if (mem_en && !mem_wr) mem_rdata <= {2'b01, mem_addr};
  end

  typedef struct {
    int rst;
    int q0, w0, a0, l0, d0;
    int q1, w1, a1, l1, d1;
    int g0, g1, v0, v1, bsy, en, mw, ma, md, rd;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int got, input int exp);
    nvec++;
    if (got != exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  initial begin
    logic [28:0] got, exp;
    //          rst q0 w0 a0 l0 d0     q1 w1 a1 l1 d1      g0 g1 v0 v1 bsy en mw ma md     rd
    tbl.push_back('{0, 1, 1, 12, 3, 'hA0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0, 0, 0, 0,     0});
    tbl.push_back('{1, 1, 1, 12, 3, 'hA0, 0, 0, 0, 0, 0,      1, 0, 0, 0, 1, 1, 1, 12, 'hA0, 0});
    tbl.push_back('{1, 0, 1, 12, 3, 'hA1, 0, 0, 0, 0, 0,      1, 0, 0, 0, 1, 1, 1, 13, 'hA1, 0});
    tbl.push_back('{1, 0, 1, 12, 3, 'hA2, 0, 0, 0, 0, 0,      1, 0, 0, 0, 1, 1, 1, 14, 'hA2, 0});
    tbl.push_back('{1, 0, 1, 12, 3, 'hA3, 0, 0, 0, 0, 0,      1, 0, 0, 0, 1, 1, 1, 15, 'hA3, 0});
    tbl.push_back('{1, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0, 0, 0, 0,     0});
    tbl.push_back('{1, 0, 0, 0, 0, 0,     1, 0, 23, 1, 0,     0, 1, 0, 0, 1, 1, 0, 23, 0,    0});
    tbl.push_back('{1, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0,      0, 1, 0, 1, 1, 1, 0, 24, 0,    'h57});
    tbl.push_back('{1, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0,      0, 0, 0, 1, 0, 0, 0, 0, 0,     'h58});
    tbl.push_back('{1, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0, 0, 0, 0,     'h58});
    tbl.push_back('{1, 1, 0, 62, 3, 0,    0, 0, 0, 0, 0,      1, 0, 0, 0, 1, 1, 0, 62, 0,    'h58});
    tbl.push_back('{1, 0, 0, 0, 0, 0,     1, 1, 5, 0, 'h99,   1, 0, 1, 0, 1, 1, 0, 63, 0,    'h7E});
    tbl.push_back('{1, 0, 0, 0, 0, 0,     1, 1, 5, 0, 'h99,   1, 0, 1, 0, 1, 1, 0, 0, 0,     'h7F});
    tbl.push_back('{1, 0, 0, 0, 0, 0,     1, 1, 5, 0, 'h99,   1, 0, 1, 0, 1, 1, 0, 1, 0,     'h40});
    tbl.push_back('{1, 0, 0, 0, 0, 0,     1, 1, 5, 0, 'h99,   0, 0, 1, 0, 0, 0, 0, 0, 0,     'h41});
    tbl.push_back('{1, 0, 0, 0, 0, 0,     1, 1, 5, 0, 'h99,   0, 1, 0, 0, 1, 1, 1, 5, 'h99,  'h41});
    tbl.push_back('{1, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0, 0, 0, 0,     'h41});
    tbl.push_back('{0, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0, 0, 0, 0,     0});
    tbl.push_back('{1, 1, 1, 48, 0, 'h11, 1, 1, 56, 0, 'h22,  1, 0, 0, 0, 1, 1, 1, 48, 'h11, 0});
    tbl.push_back('{1, 1, 1, 48, 0, 'h11, 1, 1, 56, 0, 'h22,  0, 0, 0, 0, 0, 0, 0, 0, 0,     0});
    tbl.push_back('{1, 1, 1, 48, 0, 'h11, 1, 1, 56, 0, 'h22,  0, 1, 0, 0, 1, 1, 1, 56, 'h22, 0});
    tbl.push_back('{1, 1, 1, 48, 0, 'h11, 1, 1, 56, 0, 'h22,  0, 0, 0, 0, 0, 0, 0, 0, 0,     0});
    tbl.push_back('{1, 1, 1, 48, 0, 'h11, 1, 1, 56, 0, 'h22,  1, 0, 0, 0, 1, 1, 1, 48, 'h11, 0});
    tbl.push_back('{1, 1, 1, 48, 0, 'h11, 1, 1, 56, 0, 'h22,  0, 0, 0, 0, 0, 0, 0, 0, 0,     0});
    tbl.push_back('{1, 1, 1, 48, 0, 'h11, 1, 1, 56, 0, 'h22,  0, 1, 0, 0, 1, 1, 1, 56, 'h22, 0});
    tbl.push_back('{1, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0, 0, 0, 0,     0});

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst_n  = tbl[i].rst[0];
      req0   = tbl[i].q0[0];  wr0 = tbl[i].w0[0];  addr0 = tbl[i].a0[5:0];
      len0   = tbl[i].l0[1:0]; wdata0 = tbl[i].d0[7:0];
      req1   = tbl[i].q1[0];  wr1 = tbl[i].w1[0];  addr1 = tbl[i].a1[5:0];
      len1   = tbl[i].l1[1:0]; wdata1 = tbl[i].d1[7:0];
      @(posedge clk);
      #1;
      got = {gnt0, gnt1, rvalid0, rvalid1, busy, mem_en, mem_wr, mem_addr, mem_wdata, rdata};
      exp = {tbl[i].g0[0], tbl[i].g1[0], tbl[i].v0[0], tbl[i].v1[0], tbl[i].bsy[0],
             tbl[i].en[0], tbl[i].mw[0], tbl[i].ma[5:0], tbl[i].md[7:0], tbl[i].rd[7:0]};
      nvec++;
      if (got !== exp) begin
        nmis++;
        $display("FAIL row%0d: got g0g1v0v1bsy_en_wr=%b addr=%0d wdata=%h rdata=%h expected %b addr=%0d wdata=%h rdata=%h",
                 i, got[28:22], got[21:16], got[15:8], got[7:0],
                 exp[28:22], exp[21:16], exp[15:8], exp[7:0]);
      end
    end

    // Mid-burst reset: client 0 read burst, then rr state must return to client 0.
    @(negedge clk);
    req0 = 1'b1; wr0 = 1'b0; addr0 = 6'd32; len0 = 2'd3;
    req1 = 1'b0; wr1 = 1'b0; addr1 = 6'd0; len1 = 2'd0;
    @(posedge clk);
    @(negedge clk);
    req0 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("beat2_addr", int'(mem_addr), 34);
    chk("beat2_gnt0", int'(gnt0), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_mem_en", int'(mem_en), 0);
    chk("async_gnt0", int'(gnt0), 0);
    chk("async_busy", int'(busy), 0);
    chk("async_rvalid0", int'(rvalid0), 0);
    @(posedge clk);
    #1;
    chk("no_rvalid_after_rst", int'(rvalid0), 0);
    chk("no_beat_after_rst", int'(mem_en), 0);
    @(negedge clk);
    rst_n = 1'b1;
    req0 = 1'b1; wr0 = 1'b1; addr0 = 6'd7; len0 = 2'd0;
    req1 = 1'b1; wr1 = 1'b1; addr1 = 6'd9; len1 = 2'd0;
    @(posedge clk);
    #1;
    chk("post_rst_gnt0", int'(gnt0), 1);
    chk("post_rst_gnt1", int'(gnt1), 0);
    chk("post_rst_addr", int'(mem_addr), 7);
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
